// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes, FSM states,
// and byte-lane helpers used by the store path and the load extractor.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, LOAD_CAP} state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // f3[1:0] encodes the access size for every legal load and store
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Pipeline request/response and data-RAM port bundle for the load/store unit.
// The slave modport is the unit's view; master is the surrounding pipeline/RAM.
interface lsu_mem_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int WORD_AW = 30
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_funct3;
  logic [ADDR_W-1:0]  req_addr;
  logic [31:0]        req_wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               dmem_we;
  logic [3:0]         dmem_byteEnable;
  logic [WORD_AW-1:0] dmem_address;
  logic [31:0]        dmem_wd;
  logic [31:0]        dmem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           dmem_we, dmem_byteEnable, dmem_address, dmem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           dmem_we, dmem_byteEnable, dmem_address, dmem_wd
  );
endinterface

// File: rtl/lsu_mem_stage_load_extract.sv
// Selects the addressed byte/half/word from the RAM read word and sign/zero-extends it.
// Purely combinational; unknown funct3 yields zero.
module load_extract
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      F3_LW:   result = rd;
      default: result = 32'h0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit in front of a word-addressed RAM with registered read.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WORD_AW = 30
) (
  input  logic          clk,
  input  logic          reset,
  lsu_mem_stage_if.slave bus
);
  state_t      state_reg, state_next;
  logic [2:0]  f3_reg;
  logic [1:0]  off_reg;
  logic        rsp_valid_reg, rsp_err_reg;
  logic [31:0] rsp_rdata_reg;
  logic [31:0] load_result;

  logic        accept, legal, err_req;
  logic [1:0]  off, eff_off;
  logic        do_store, do_load, do_err;

  assign off    = bus.req_addr[1:0];
  assign legal  = f3_legal(bus.req_we, bus.req_funct3);
  assign accept = bus.req_valid && (state_reg == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign err_req = !legal || misaligned(bus.req_funct3, off);
  assign eff_off = off;
`else
  // Misaligned halves/words silently snap to their natural boundary
  assign err_req = !legal;
  assign eff_off = align_off(bus.req_funct3, off);
`endif

  always_comb begin
    state_next          = state_reg;
    bus.dmem_we         = 1'b0;
    bus.dmem_byteEnable = 4'b0000;
    do_store            = 1'b0;
    do_load             = 1'b0;
    do_err              = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (err_req) begin
            do_err = 1'b1;
          end else if (bus.req_we) begin
            bus.dmem_we         = 1'b1;
            bus.dmem_byteEnable = byte_en(bus.req_funct3, eff_off);
            do_store            = 1'b1;
          end else begin
            do_load    = 1'b1;
            state_next = LOAD_CAP;
          end
        end
      end
      LOAD_CAP: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign bus.req_ready    = (state_reg == IDLE);
  assign bus.dmem_address = bus.req_addr[ADDR_W-1:ADDR_W-WORD_AW];
  assign bus.dmem_wd      = lane_data(bus.req_funct3, bus.req_wdata);

  load_extract u_load_extract (
    .rd     (bus.dmem_rd),
    .funct3 (f3_reg),
    .off    (off_reg),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      f3_reg        <= 3'b000;
      off_reg       <= 2'b00;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= 1'b0;
      if (do_load) begin
        f3_reg  <= bus.req_funct3;
        off_reg <= eff_off;
      end
      // Response data holds between pulses; only a completing op overwrites it
      if (state_reg == LOAD_CAP) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= load_result;
        rsp_err_reg   <= 1'b0;
      end else if (do_store || do_err) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= 32'h0;
        rsp_err_reg   <= do_err;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural RAM and a response scoreboard.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:63];

  lsu_mem_stage_if #(.ADDR_W(32), .WORD_AW(30)) bus ();

  lsu_mem_stage #(.ADDR_W(32), .WORD_AW(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte-lane writes, registered read on non-write cycles
  always @(posedge clk) begin
    if (bus.dmem_we) begin
      for (int l = 0; l < 4; l++)
        if (bus.dmem_byteEnable[l])
          mem[bus.dmem_address[5:0]][8*l +: 8] <= bus.dmem_wd[8*l +: 8];
    end else begin
      bus.dmem_rd <= mem[bus.dmem_address[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_without_request", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp %s cycle=%0d rdata=0x%08h err=%0b", e.tag, cyc, bus.rsp_rdata, bus.rsp_err);
        check({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        check({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // One request; checks the RAM-side outputs in the accept cycle and queues the response
  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic exp_we, input logic [3:0] exp_be,
                    input logic chk_wd, input logic [31:0] exp_wd,
                    input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                    input string tag);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_we"}, 32'(bus.dmem_we), 32'(exp_we));
    check({tag, "_be"}, 32'(bus.dmem_byteEnable), 32'(exp_be));
    check({tag, "_address"}, 32'(bus.dmem_address), addr >> 2);
    if (chk_wd) check({tag, "_wd"}, bus.dmem_wd, exp_wd);
    sb.push_back('{exp_rdata, exp_err, cyc + lat, tag});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (lat == 2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_we", 32'(bus.dmem_we), 32'd0);

    //  we    f3      addr   wdata         xwe  xbe      wd?  xwd          rdata        err lat tag
    op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0,       0, 1, "sw_10");
    op(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1, 4'b1000, 1'b1, 32'hA5A5A5A5, 32'h0,       0, 1, "sb_13");
    op(1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h000000A5, 0, 2, "lbu_13");
    op(1'b1, 3'b010, 32'h20, 32'h8000F0FF, 1'b1, 4'b1111, 1'b1, 32'h8000F0FF, 32'h0,       0, 1, "sw_20");
    op(1'b0, 3'b000, 32'h20, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'hFFFFFFFF, 0, 2, "lb_20");
    op(1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'hFFFF8000, 0, 2, "lh_22");
    op(1'b0, 3'b101, 32'h22, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h00008000, 0, 2, "lhu_22");
`ifdef LSU_MISALIGN_TRAP_EN
    op(1'b0, 3'b010, 32'h21, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       1, 1, "lw_21_trap");
`else
    op(1'b0, 3'b010, 32'h21, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h8000F0FF, 0, 2, "lw_21_align");
`endif

    // Load followed by a store with req_valid held throughout
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    #1;
    check("b2b_load_ready", 32'(bus.req_ready), 32'd1);
    sb.push_back('{32'hA5ADBEEF, 1'b0, cyc + 2, "b2b_lw_10"});
    @(posedge clk); #1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h14;
    bus.req_wdata  = 32'h00000055;
    #1;
    check("b2b_ready_low", 32'(bus.req_ready), 32'd0);
    check("b2b_no_write_in_cap", 32'(bus.dmem_we), 32'd0);
    @(posedge clk); #1;
    check("b2b_store_ready", 32'(bus.req_ready), 32'd1);
    check("b2b_store_rsp_overlap", 32'(bus.rsp_valid), 32'd1);
    check("b2b_store_we", 32'(bus.dmem_we), 32'd1);
    check("b2b_store_be", 32'(bus.dmem_byteEnable), 32'hF);
    check("b2b_store_address", 32'(bus.dmem_address), 32'h5);
    sb.push_back('{32'h0, 1'b0, cyc + 1, "b2b_sw_14"});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    op(1'b0, 3'b010, 32'h14, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h00000055, 0, 2, "lw_14");
    op(1'b1, 3'b001, 32'h16, 32'hABCD1234, 1'b1, 4'b1100, 1'b1, 32'h12341234, 32'h0,       0, 1, "sh_16");
    op(1'b0, 3'b101, 32'h16, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h00001234, 0, 2, "lhu_16");
`ifdef LSU_MISALIGN_TRAP_EN
    op(1'b1, 3'b001, 32'h17, 32'h00007777, 1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       1, 1, "sh_17_trap");
    op(1'b0, 3'b001, 32'h17, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       1, 1, "lh_17_trap");
`else
    op(1'b1, 3'b001, 32'h17, 32'h00007777, 1'b1, 4'b1100, 1'b1, 32'h77777777, 32'h0,       0, 1, "sh_17_align");
    op(1'b0, 3'b001, 32'h17, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h00007777, 0, 2, "lh_17_align");
`endif
    op(1'b1, 3'b100, 32'h18, 32'h11111111, 1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       1, 1, "store_f3_100");
    op(1'b0, 3'b011, 32'h18, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       1, 1, "load_f3_011");
    op(1'b0, 3'b000, 32'h20, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'hFFFFFFFF, 0, 2, "lb_20_again");

    // Reset while a load sits in LOAD_CAP drops it
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("cap_ready_low", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_cap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_cap_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_cap_ready", 32'(bus.req_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    op(1'b0, 3'b111, 32'h20, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,       1, 1, "load_f3_111");
    op(1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        32'h8000F0FF, 0, 2, "lw_20_post_rst");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
